// File: rtl/pipeline_control.sv
// pipeline_control: fetch/decode and control-word pipeline (ID/EX/MEM/WB) with branch resolution, hazard stalls and flushes
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   imem_addr/imem_data fetch address (pcIF) and the instruction read combinationally at it
//   r_for_pc            rs1 value of the EX instruction (jalr base)
//   funit_ZCNVFlags     EX compare flags {Z,C,N,V}
//   cwordID..cwordWB    23-bit control words {rs2,rs1,rd,fun7,fun3,instType}
//   pc, immEX, immMEM   EX-stage PC and decoded immediates in EX/MEM
//   stall, flush        ID held / redirect taken this cycle
module pipeline_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic [31:0] r_for_pc,
  input  logic [3:0]  funit_ZCNVFlags,
  output logic [22:0] cwordID,
  output logic [22:0] cwordEX,
  output logic [22:0] cwordMEM,
  output logic [22:0] cwordWB,
  output logic [31:0] pc,
  output logic [31:0] immEX,
  output logic [31:0] immMEM,
  output logic        stall,
  output logic        flush
);
  localparam logic [22:0] BUBBLE = 23'h000006;
  logic [31:0] ir, ir_pc, imm_id, target;
  logic [3:0] t;
  logic [4:0] rd, rs1, rs2;
  logic v_id, v_ex, v_mem, v_wb, taken, hz;
  function automatic logic writes(input logic v, input logic [22:0] cw, input logic [4:0] r);
    return v && cw[3:0] != 4'd2 && cw[3:0] != 4'd6 && cw[12:8] == r;
  endfunction
  // An all-zero instruction word has an unknown opcode, so it doubles as the IF/ID bubble.
  always_comb begin
    t = ir[6:0] == 7'b0000011 ? 4'd0 :
        ir[6:0] == 7'b0010011 ? 4'd1 :
        ir[6:0] == 7'b0100011 ? 4'd2 :
        ir[6:0] == 7'b0110011 ? 4'd3 :
        ir[6:0] == 7'b0110111 ? 4'd4 :
        ir[6:0] == 7'b0010111 ? 4'd5 :
        ir[6:0] == 7'b1100011 ? 4'd6 :
        ir[6:0] == 7'b1100111 ? 4'd7 :
        ir[6:0] == 7'b1101111 ? 4'd8 : 4'd15;
    v_id = t != 4'd15;
    rd = (t == 4'd2 || t == 4'd6) ? 5'd0 : ir[11:7];
    rs1 = (t == 4'd4 || t == 4'd5 || t == 4'd8) ? 5'd0 : ir[19:15];
    rs2 = (t == 4'd2 || t == 4'd3 || t == 4'd6) ? ir[24:20] : 5'd0;
    cwordID = v_id ? {rs2, rs1, rd, ir[30], ir[14:12], t} : BUBBLE;
    imm_id = (t == 4'd0 || t == 4'd1 || t == 4'd7) ? {{20{ir[31]}}, ir[31:20]} :
             t == 4'd2 ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
             t == 4'd6 ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
             (t == 4'd4 || t == 4'd5) ? {ir[31:12], 12'b0} :
             t == 4'd8 ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} : 32'd0;
  end
  always_comb begin
    taken = cwordEX[6:4] == 3'd0 ? funit_ZCNVFlags[3] :
            cwordEX[6:4] == 3'd1 ? !funit_ZCNVFlags[3] :
            cwordEX[6:4] == 3'd4 ? funit_ZCNVFlags[1] ^ funit_ZCNVFlags[0] :
            cwordEX[6:4] == 3'd5 ? !(funit_ZCNVFlags[1] ^ funit_ZCNVFlags[0]) :
            cwordEX[6:4] == 3'd6 ? !funit_ZCNVFlags[2] :
            cwordEX[6:4] == 3'd7 ? funit_ZCNVFlags[2] : 1'b0;
    flush = v_ex && ((cwordEX[3:0] == 4'd6 && taken) || cwordEX[3:0] == 4'd7 || cwordEX[3:0] == 4'd8);
    target = cwordEX[3:0] == 4'd7 ? (r_for_pc + immEX) & ~32'd1 : pc + immEX;
    // jalr reads its base in EX, so it must wait until no in-flight writer targets rs1.
    hz = (v_ex && cwordEX[3:0] == 4'd0 && cwordEX[12:8] != 5'd0 &&
          (cwordEX[12:8] == rs1 || cwordEX[12:8] == rs2)) ||
         (v_id && t == 4'd7 && rs1 != 5'd0 &&
          (writes(v_ex, cwordEX, rs1) || writes(v_mem, cwordMEM, rs1) || writes(v_wb, cwordWB, rs1)));
    stall = hz && !flush;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_addr <= RESET_PC;
      ir <= 32'd0;
      ir_pc <= 32'd0;
      cwordEX <= BUBBLE;
      cwordMEM <= BUBBLE;
      cwordWB <= BUBBLE;
      v_ex <= 1'b0;
      v_mem <= 1'b0;
      v_wb <= 1'b0;
      pc <= 32'd0;
      immEX <= 32'd0;
      immMEM <= 32'd0;
    end else begin
      imem_addr <= flush ? target : hz ? imem_addr : imem_addr + 32'd4;
      ir <= flush ? 32'd0 : hz ? ir : imem_data;
      ir_pc <= hz && !flush ? ir_pc : imem_addr;
      cwordEX <= (flush || hz) ? BUBBLE : cwordID;
      v_ex <= !(flush || hz) && v_id;
      immEX <= (flush || hz) ? 32'd0 : imm_id;
      pc <= ir_pc;
      cwordMEM <= cwordEX;
      v_mem <= v_ex;
      immMEM <= immEX;
      cwordWB <= cwordMEM;
      v_wb <= v_mem;
    end
  end
endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: table + scoreboard checks of decode/EX flow, plus hand sequences for stalls, redirects and reset
module tb_pipeline_control;
  localparam logic [22:0] BUBBLE = 23'h000006;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] imem_addr, imem_data, r_for_pc = 32'd0, pc, immEX, immMEM, off;
  logic [3:0] flags = 4'd0;
  logic [22:0] cwordID, cwordEX, cwordMEM, cwordWB;
  logic stall, flush;
  logic [31:0] prog [128];
  int cyc, n_tests = 0, n_fail = 0;
  typedef struct {logic [31:0] instr; logic [22:0] cw; logic [31:0] imm; logic chk_imm;} vec_t;
  typedef struct {logic [22:0] cw; logic [31:0] imm; logic chk_imm; logic [31:0] pc; int due;} sb_t;
  vec_t tbl [9];
  sb_t sb [$];
  sb_t e;

  pipeline_control #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .r_for_pc(r_for_pc), .funit_ZCNVFlags(flags),
    .cwordID(cwordID), .cwordEX(cwordEX), .cwordMEM(cwordMEM), .cwordWB(cwordWB),
    .pc(pc), .immEX(immEX), .immMEM(immMEM), .stall(stall), .flush(flush)
  );

  always #5 clk = ~clk;
  assign off = imem_addr - 32'h100;
  assign imem_data = off < 32'd512 ? prog[off[8:2]] : 32'h0000_0013;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic nops();
    for (int i = 0; i < 128; i++) prog[i] = 32'h0000_0013;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && sb.size() != 0) begin
      if (sb[0].due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_timeout: entry due at cyc %0d not seen by cyc %0d", sb[0].due, cyc);
        sb.delete(0);
      end else if (sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("sb_cwordEX", {9'd0, cwordEX}, {9'd0, e.cw});
        if (e.chk_imm) chk("sb_immEX", immEX, e.imm);
        if (e.cw != BUBBLE) chk("sb_pc", pc, e.pc);
      end
    end
  end

  task automatic run_branch(input logic z);
    nops();
    prog[0] = 32'h1000_006F;
    prog[64] = 32'h0420_8063;
    flags = z ? 4'b1000 : 4'b0000;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) chk("jal_flush", {31'd0, flush}, 32'd1);
      if (c == 3) chk("jal_target", imem_addr, 32'h200);
      if (c == 5) begin
        chk("beq_flush", {31'd0, flush}, {31'd0, z});
        chk("beq_pc", pc, 32'h200);
        chk("beq_imm", immEX, 32'h40);
      end
      if (c == 6) begin
        chk("beq_next_addr", imem_addr, z ? 32'h240 : 32'h20C);
        chk("beq_mem", {9'd0, cwordMEM}, 32'h082006);
        chk("beq_young_ex", {9'd0, cwordEX}, z ? {9'd0, BUBBLE} : 32'h000001);
        if (z) chk("beq_young_id", {9'd0, cwordID}, {9'd0, BUBBLE});
      end
    end
  endtask

  initial begin
    int stalls;
    tbl[0] = '{32'h00A0_0093, 23'h000101, 32'd10, 1'b1};
    tbl[1] = '{32'h0081_2283, 23'h004520, 32'd8, 1'b1};
    tbl[2] = '{32'hFE32_2E23, 23'h0C80A2, 32'hFFFF_FFFC, 1'b1};
    tbl[3] = '{32'h4083_8333, 23'h20E683, 32'd0, 1'b0};
    tbl[4] = '{32'h1234_54B7, 23'h000954, 32'h1234_5000, 1'b1};
    tbl[5] = '{32'hFFFF_F517, 23'h000AF5, 32'hFFFF_F000, 1'b1};
    tbl[6] = '{32'h0020_8463, 23'h082006, 32'd8, 1'b1};
    tbl[7] = '{32'hFFFF_FFFF, BUBBLE, 32'd0, 1'b0};
    tbl[8] = '{32'hFFF6_0593, 23'h018B81, 32'hFFFF_FFFF, 1'b1};
    nops();
    for (int i = 0; i < 9; i++) prog[i] = tbl[i].instr;
    do_reset();
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_cwID", {9'd0, cwordID}, {9'd0, BUBBLE});
    chk("rst_cwEX", {9'd0, cwordEX}, {9'd0, BUBBLE});
    chk("rst_cwMEM", {9'd0, cwordMEM}, {9'd0, BUBBLE});
    chk("rst_cwWB", {9'd0, cwordWB}, {9'd0, BUBBLE});
    chk("rst_pc", pc, 32'd0);
    chk("rst_immEX", immEX, 32'd0);
    chk("rst_immMEM", immMEM, 32'd0);
    chk("rst_stall_flush", {30'd0, stall, flush}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      chk("fetch_addr", imem_addr, 32'h100 + 32'(4 * i));
      if (i < 2) chk("early_cwEX", {9'd0, cwordEX}, {9'd0, BUBBLE});
      if (i == 1) chk("addi_cwID", {9'd0, cwordID}, {9'd0, tbl[0].cw});
      sb.push_back('{tbl[i].cw, tbl[i].imm, tbl[i].chk_imm, imem_addr, cyc + 2});
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("sb_drain", sb.size(), 32'd0);

    nops();
    prog[0] = 32'h0001_2283;
    prog[1] = 32'h0052_8333;
    do_reset();
    stalls = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      stalls += int'(stall);
      if (c == 2) chk("lu_stall", {31'd0, stall}, 32'd1);
      if (c == 3) begin
        chk("lu_bubble", {9'd0, cwordEX}, {9'd0, BUBBLE});
        chk("lu_hold_addr", imem_addr, 32'h108);
        chk("lu_lw_mem", {9'd0, cwordMEM}, 32'h004520);
      end
      if (c == 4) chk("lu_add_ex", {9'd0, cwordEX}, 32'h14A603);
    end
    chk("lu_count", stalls, 32'd1);

    run_branch(1'b1);
    run_branch(1'b0);

    nops();
    prog[0] = 32'h0043_80E7;
    flags = 4'd0;
    r_for_pc = 32'h1003;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 2) begin
        chk("jalr_flush", {31'd0, flush}, 32'd1);
        chk("jalr_cwEX", {9'd0, cwordEX}, 32'h00E107);
      end
      if (c == 3) chk("jalr_target", imem_addr, 32'h1006);
    end

    nops();
    prog[0] = 32'h0010_0393;
    prog[1] = 32'h0043_80E7;
    do_reset();
    stalls = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c <= 5) stalls += int'(stall);
      if (c == 4) chk("jh_addi_wb", {9'd0, cwordWB}, 32'h000701);
      if (c == 5) begin
        chk("jh_released", {31'd0, stall}, 32'd0);
        chk("jh_id_held", {9'd0, cwordID}, 32'h00E107);
      end
      if (c == 6) chk("jh_flush", {31'd0, flush}, 32'd1);
      if (c == 7) chk("jh_target", imem_addr, 32'h1006);
    end
    chk("jh_count", stalls, 32'd3);

    nops();
    prog[0] = 32'h0001_2283;
    prog[1] = 32'h0052_8333;
    do_reset();
    step();
    step();
    chk("mr_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_addr", imem_addr, 32'h100);
    chk("mr_cwID", {9'd0, cwordID}, {9'd0, BUBBLE});
    chk("mr_cwEX", {9'd0, cwordEX}, {9'd0, BUBBLE});
    chk("mr_cwMEM", {9'd0, cwordMEM}, {9'd0, BUBBLE});
    chk("mr_cwWB", {9'd0, cwordWB}, {9'd0, BUBBLE});
    chk("mr_stall_off", {31'd0, stall}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Fetch/decode and pipeline-control stage that feeds the integer datapath.
- Fetches instructions, decodes them into 23-bit control words and immediates, and shifts those through the ID/EX/MEM/WB control registers.
- Resolves branches and jumps in EX from the datapath's flags and rs1 value.
- Inserts bubbles for load-use and jalr hazards, and flushes wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- imem_addr  output  32  fetch address (pcIF); instruction memory reads combinationally
- imem_data  input  32  instruction at imem_addr
- r_for_pc  input  32  rs1 value of the EX instruction (jalr base)
- funit_ZCNVFlags  input  4  EX compare flags: [3]Z [2]C [1]N [0]V; C=1 means no borrow (A>=B unsigned)
- cwordID, cwordEX, cwordMEM, cwordWB  output  23 each  control words: [3:0] instType, [6:4] fun3, [7] fun7 (instr[30]), [12:8] rd, [17:13] rs1, [22:18] rs2
- pc  output  32  PC of the EX-stage instruction
- immEX, immMEM  output  32  decoded immediate in EX / MEM
- stall  output  1  ID held this cycle
- flush  output  1  redirect taken this cycle

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high (rst). Ports are named clk and rst, as in the rest of the codebase.
- Reset values:
  - pcIF = RESET_PC.
  - IF/ID instruction = bubble, all cwords = BUBBLE (23'h000006, instType 6 with all register fields 0), every stage valid bit = 0.
  - pc, immEX, immMEM = 0; stall = flush = 0.
- Reset mid-operation discards all in-flight state immediately.
- instType decode from opcode:
  - 0000011 load = 0; 0010011 imm = 1; 0100011 store = 2; 0110011 reg = 3; 0110111 lui = 4.
  - 0010111 auipc = 5; 1100011 branch = 6; 1100111 jalr = 7; 1101111 jal = 8.
  - Any other opcode decodes to BUBBLE with valid = 0.
- rd/rs1/rs2 come from instr[11:7], [19:15], [24:20].
  - Force rd = 0 for store and branch.
  - Force rs2 = 0 for every type except store, reg and branch.
  - Force rs1 = 0 for lui, auipc and jal.
- Immediates, all sign-extended to 32 bits:
  - I-format: load, imm, jalr.
  - S-format: store.
  - B-format: branch.
  - U-format ({instr[31:12], 12'b0}): lui, auipc.
  - J-format: jal.
- Each stage carries a valid bit. A BUBBLE is never treated as a branch.
- Branch condition in EX, by fun3EX:
  - beq Z; bne !Z.
  - blt N^V; bge !(N^V).
  - bltu !C; bgeu C.
  - fun3 010 and 011 are never taken.
- Redirect (valid EX instruction only):
  - Taken branch and jal: target = pc + immEX.
  - jalr: target = (r_for_pc + immEX) & ~1.
  - All address arithmetic is 32-bit and wraps modulo 2^32.
- On redirect:
  - pcIF <= target.
  - IF/ID <= bubble and ID/EX <= BUBBLE; two-cycle penalty.
  - flush = 1 for that cycle.
- Load-use stall: EX is a valid load with rdEX != 0 and rdEX equal to rs1ID or rs2ID.
- jalr stall: ID is jalr with rs1ID != 0, and rs1ID equals rd of any valid writing instruction in EX, MEM or WB (any type except store and branch).
- On stall:
  - pcIF and IF/ID hold; ID/EX <= BUBBLE; MEM/WB advance.
  - stall = 1.
- Redirect has priority over stall in the same cycle; flush = 1, stall = 0.
- Otherwise every register advances each cycle and pcIF <= pcIF + 4.
- The register file forwards same-cycle WB writes to ID reads, so a WB-to-ID dependency needs no stall.

Test Plan:
- Reset with RESET_PC = 0x100, release rst → imem_addr = 0x100, 0x104, 0x108 on successive cycles; cwordEX = 23'h000006 until the first instruction reaches EX.
- Instruction 0x00A00093 (addi x1,x0,10) → cwordID: instType 1, fun3 0, rd 1, rs1 0, rs2 0; one cycle later immEX = 10, pc = its fetch address.
- lw x5,0(x2) followed by add x6,x5,x5 → exactly one stall cycle (stall = 1); add reaches EX with a BUBBLE between it and lw.
- beq at 0x200 with immEX = 0x40 and Z = 1 → flush = 1; next imem_addr = 0x240; the two younger instructions become BUBBLE. With Z = 0 → no flush, sequential fetch.
- jalr x1,4(x7) with r_for_pc = 0x1003 → imem_addr = 0x1006 next cycle. With x7 written by the preceding addi → held in ID until the addi leaves WB.
- Asserting rst mid-stream while a stall is active → all cwords return to BUBBLE and imem_addr to RESET_PC without waiting for a clock edge.
